// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-to-decode buffer.
package fetch_pkg;

  localparam int unsigned FetchFifoDepth = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ring_ptr.sv
// Wrap-around pointer: advances on inc, returns to zero on clr (clr wins).
module ring_ptr #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] ptr
);

  logic [Width-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fetch_fifo.sv
// Fetch-to-decode decoupling FIFO with single-cycle flush.
// Define FETCH_FIFO_BYPASS_EN for a zero-latency path when the buffer is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = FetchFifoDepth
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  fetch_entry_t            mem_q [Depth];
  logic [CntW-1:0]         count_q, count_d;
  logic [PtrW-1:0]         rd_ptr, wr_ptr;
  logic                    push, pop, bypass;
  fetch_entry_t            head;

  assign in_ready = (count_q != CntFull);
  assign head     = mem_q[rd_ptr];

`ifdef FETCH_FIFO_BYPASS_EN
  // Reset gating keeps the combinational path quiet while reset is held.
  assign bypass = reset && !flush && in_valid && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign pop  = (count_q != '0) && out_ready && !flush;
  // A bypassed pair taken by decode this cycle is never stored.
  assign push = in_valid && in_ready && !flush && !(bypass && out_ready);

  always_comb begin
    out_valid = (count_q != '0);
    out_pc    = head.pc;
    out_instr = head.instr;
    if (bypass) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end
  end

  ring_ptr #(.Width(PtrW)) u_rd_ptr (
    .clk  (clk),
    .reset(reset),
    .inc  (pop),
    .clr  (flush),
    .ptr  (rd_ptr)
  );

  ring_ptr #(.Width(PtrW)) u_wr_ptr (
    .clk  (clk),
    .reset(reset),
    .inc  (push),
    .clr  (flush),
    .ptr  (wr_ptr)
  );

  assign count = count_q;

endmodule

// File: tb/tb_fetch_fifo.sv
// Directed bench for fetch_fifo (Depth 4) with a queue tracking expected order.
module tb_fetch_fifo;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int          total = 0;
  int          bad = 0;
  logic [31:0] q[$];

  fetch_fifo #(.Depth(Depth)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One handshake cycle; expected pop order and count come from the queue.
  task automatic cyc(input logic v, input logic r, input logic [31:0] pc);
    logic do_push, do_pop;
    in_valid  = v;
    out_ready = r;
    in_pc     = pc;
    in_instr  = pc ^ 32'h13;
    #1;
    do_push = v && (q.size() < int'(Depth));
    do_pop  = r && (q.size() > 0);
    if (do_pop) chk("order", out_pc, q[0]);
    tick();
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(pc);
    chk("count", 32'(count), 32'(q.size()));
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] npush;
    logic [1:0]  pat [15];

    // Reset held with traffic at the input
    in_valid = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    tick();
    chk("rst_hold_count", 32'(count), 32'd0);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 32'h0);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_instr", out_instr, 32'h13);
    cyc(1'b0, 1'b1, 32'h0);

    // Fill, overflow attempt, drain
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'(i * 4));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cyc(1'b1, 1'b0, 32'h10);
    chk("refused_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h0);
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Wrap-around: 0=push, 1=pop, 2=both
    pat = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1,
            2'd2, 2'd2, 2'd0, 2'd1};
    npush = 0;
    for (int i = 0; i < 15; i++) begin
      if (pat[i] == 2'd1) begin
        cyc(1'b0, 1'b1, 32'h0);
      end else begin
        cyc(1'b1, pat[i] == 2'd2, npush * 4);
        npush++;
      end
    end
    cyc(1'b0, 1'b1, 32'h0);
    chk("wrap_pushes", npush, 32'd10);
    chk("wrap_empty", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at count 2 and at full
    cyc(1'b1, 1'b0, 32'ha0);
    cyc(1'b1, 1'b0, 32'ha4);
    cyc(1'b1, 1'b1, 32'ha8);
    chk("pp_count2", 32'(count), 32'd2);
    cyc(1'b1, 1'b0, 32'hac);
    cyc(1'b1, 1'b0, 32'hb0);
    out_ready = 1'b1;
    #1;
    chk("full_pp_in_ready", 32'(in_ready), 32'd0);
    cyc(1'b1, 1'b1, 32'hb4);
    chk("full_pp_count3", 32'(count), 32'd3);

    // Flush with a pair presented in the same cycle
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_pc     = 32'hdeadbeef;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 1'b0, 32'h100);
    chk("post_flush_pc", out_pc, 32'h100);
    cyc(1'b1, 1'b0, 32'h104);
    cyc(1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b1, 32'h0);

    // Asynchronous reset in the middle of traffic
    cyc(1'b1, 1'b0, 32'h200);
    cyc(1'b1, 1'b0, 32'h204);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_pc", out_pc, 32'h0);
    q.delete();
    tick();
    reset = 1'b1;

    // Empty buffer, pair offered with decode ready
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_pc     = 32'h40;
    in_instr  = 32'h53;
    #1;
`ifdef FETCH_FIFO_BYPASS_EN
    chk("byp_valid", 32'(out_valid), 32'd1);
    chk("byp_pc", out_pc, 32'h40);
    tick();
    in_valid = 1'b0;
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("nobyp_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("nobyp_count", 32'(count), 32'd1);
    chk("nobyp_pc", out_pc, 32'h40);
    tick();
    chk("nobyp_drain", 32'(count), 32'd0);
`endif
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
